// File: rtl/pipelined_addsub.sv
// pipelined_addsub: N-bit adder/subtractor, carry split into SEG-bit segments
// one segment per stage, valid/ready flow control through a single global stall
module pipelined_addsub #(
   parameter int N   = 16,
   parameter int SEG = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] S,
   output logic         Cout,
   output logic         ovf
);

   localparam int STAGES = N / SEG;

   logic         stall;
   logic [N-1:0] beff;
   logic         c0;

   assign beff = sub ? ~B : B;
   assign c0   = sub ? ~cin : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // W: operand bits not yet consumed; SW: sum bits resolved after this stage
      localparam int W  = N - k * SEG;
      localparam int SW = (k + 1) * SEG;

      logic [W-1:0]  a_in;
      logic [W-1:0]  b_in;
      logic          c_in;
      logic          v_in;
      logic [SEG:0]  seg;
      logic [SW-1:0] s_d;
      logic [SW-1:0] s_q;
      logic          c_q;
      logic          v_q;

      if (k == 0) begin : g_head
         assign a_in = A;
         assign b_in = beff;
         assign c_in = c0;
         assign v_in = in_valid;
         assign s_d  = seg[SEG-1:0];
      end else begin : g_body
         assign a_in = g_st[k-1].g_fwd.a_q;
         assign b_in = g_st[k-1].g_fwd.b_q;
         assign c_in = g_st[k-1].c_q;
         assign v_in = g_st[k-1].v_q;
         assign s_d  = {seg[SEG-1:0], g_st[k-1].s_q};
      end

      assign seg = {1'b0, a_in[SEG-1:0]}
                 + {1'b0, b_in[SEG-1:0]}
                 + {{SEG{1'b0}}, c_in};

      // latch this stage's sum segment, its carry and the beat's valid bit
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (!stall) begin
            v_q <= v_in;
            c_q <= seg[SEG];
            s_q <= s_d;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [W-SEG-1:0] a_q;
         logic [W-SEG-1:0] b_q;

         // skew the still-unused upper operand segments to the next stage
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall) begin
               a_q <= a_in[W-1:SEG];
               b_q <= b_in[W-1:SEG];
            end
         end
      end else begin : g_tail
         logic ovf_d;
         logic ovf_q;

         // top segment holds both operand sign bits and the result sign bit
         assign ovf_d = (a_in[SEG-1] == b_in[SEG-1])
                     && (seg[SEG-1] != a_in[SEG-1]);

         // register signed overflow alongside the final sum
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (!stall) begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign stall     = g_st[STAGES-1].v_q && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = g_st[STAGES-1].v_q;
   assign S         = g_st[STAGES-1].s_q;
   assign Cout      = g_st[STAGES-1].c_q;
   assign ovf       = g_st[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed corners and reset on a 16/4 instance,
// random throughput/backpressure sweep over four (N,SEG) configurations
module tb_pipelined_addsub;

   localparam int NB  = 10000;
   localparam int NBP = 3000;

   logic clk;
   logic rst;
   int   cyc;
   int   n_vec;
   int   n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cfg_n(int i);
      return (i == 3) ? 32 : 16;
   endfunction

   function automatic int cfg_seg(int i);
      case (i)
         0:       return 4;
         1:       return 16;
         2:       return 1;
         default: return 8;
      endcase
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // reference: exact integer arithmetic, returns {ovf, cout, s[31:0]}
   function automatic logic [33:0] model(int n, longint a, longint b,
                                         bit ci, bit sb);
      longint m, half, sa, sbv, u, sv, s;
      logic   co, ov;
      m    = longint'(1) << n;
      half = m / 2;
      sa   = (a >= half) ? a - m : a;
      sbv  = (b >= half) ? b - m : b;
      if (sb) begin
         u  = a - b - longint'(ci);
         co = (u >= 0);
         sv = sa - sbv - longint'(ci);
      end else begin
         u  = a + b + longint'(ci);
         co = (u >= m);
         sv = sa + sbv + longint'(ci);
      end
      ov = (sv >= half) || (sv < -half);
      s  = u & (m - 1);
      return {ov, co, 32'(s)};
   endfunction

   // ---------------- directed instance (N=16, SEG=4) ----------------
   logic        d_rst, d_iv, d_ir, d_ci, d_sb, d_ov, d_or, d_co, d_of;
   logic [15:0] d_a, d_b, d_s;

   pipelined_addsub #(.N(16), .SEG(4)) u_dut (
      .clk(clk), .rst(d_rst),
      .in_valid(d_iv), .in_ready(d_ir),
      .A(d_a), .B(d_b), .cin(d_ci), .sub(d_sb),
      .out_valid(d_ov), .out_ready(d_or),
      .S(d_s), .Cout(d_co), .ovf(d_of)
   );

   task automatic corner(string tag, logic [15:0] a, logic [15:0] b,
                         logic ci, logic sb,
                         logic [15:0] es, logic eco, logic eov);
      int k;
      @(negedge clk);
      d_a = a; d_b = b; d_ci = ci; d_sb = sb; d_iv = 1'b1; d_or = 1'b1;
      #1 chk({tag, "_rdy"}, 64'(d_ir), 64'(1));
      @(negedge clk);
      d_iv = 1'b0;
      k = -1;
      for (int j = 0; j < 10; j++) begin
         #1;
         if (d_ov) begin
            k = j;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_lat"}, 64'(k), 64'(3));
      chk({tag, "_S"},   64'(d_s), 64'(es));
      chk({tag, "_C"},   64'(d_co), 64'(eco));
      chk({tag, "_V"},   64'(d_of), 64'(eov));
   endtask

   // ---------------- parameter sweep instances ----------------
   for (genvar gi = 0; gi < 4; gi++) begin : g_sw
      localparam int N   = cfg_n(gi);
      localparam int SEG = cfg_seg(gi);
      localparam int ST  = N / SEG;
      localparam int DR  = 2 * ST + 8;

      logic         iv, ir, ci, sb, ov, orr, co, of;
      logic [N-1:0] a, b, s;
      bit           done;
      logic [N+1:0] expq[$];
      int           accq[$];
      bit           latq[$];

      pipelined_addsub #(.N(N), .SEG(SEG)) u_dut (
         .clk(clk), .rst(rst),
         .in_valid(iv), .in_ready(ir),
         .A(a), .B(b), .cin(ci), .sub(sb),
         .out_valid(ov), .out_ready(orr),
         .S(s), .Cout(co), .ovf(of)
      );

      initial begin : drv
         logic [N+1:0] prev, e;
         logic [33:0]  mr;
         bit           hold, lt;
         int           t, ph;
         iv = 1'b0; orr = 1'b1; ci = 1'b0; sb = 1'b0;
         a = '0; b = '0; hold = 1'b0; done = 1'b0; prev = '0;
         #2;
         while (rst) @(negedge clk);
         for (int n = 0; n < NB + ST + 4 + NBP + DR; n++) begin
            @(negedge clk);
            ph = (n < NB) ? 0 :
                 (n < NB + ST + 4) ? 1 :
                 (n < NB + ST + 4 + NBP) ? 2 : 3;
            a  = N'($urandom);
            b  = N'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            iv  = (ph == 0) ? 1'b1 : (ph == 2) ? 1'($urandom) : 1'b0;
            orr = (ph == 2) ? 1'($urandom) : 1'b1;
            #1;
            if (ph == 0 && n >= ST)
               chk($sformatf("thru_valid_%0d", gi), 64'(ov), 64'(1));
            if (hold) begin
               chk($sformatf("hold_valid_%0d", gi), 64'(ov), 64'(1));
               chk($sformatf("hold_data_%0d", gi), 64'({of, co, s}), 64'(prev));
            end
            chk($sformatf("in_ready_%0d", gi), 64'(ir), 64'(!(ov && !orr)));
            if (ov && orr) begin
               chk($sformatf("pending_%0d", gi),
                   64'(expq.size() != 0), 64'(1));
               if (expq.size() != 0) begin
                  e  = expq.pop_front();
                  t  = accq.pop_front();
                  lt = latq.pop_front();
                  chk($sformatf("result_%0d", gi), 64'({of, co, s}), 64'(e));
                  if (lt)
                     chk($sformatf("latency_%0d", gi), 64'(cyc - t), 64'(ST - 1));
               end
            end
            hold = ov && !orr;
            prev = {of, co, s};
            if (iv && ir) begin
               mr = model(N, longint'(a), longint'(b), ci, sb);
               expq.push_back({mr[33], mr[32], mr[N-1:0]});
               accq.push_back(cyc + 1);
               latq.push_back(ph == 0);
            end
         end
         chk($sformatf("drain_empty_%0d", gi), 64'(expq.size()), 64'(0));
         done = 1'b1;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int cnt;
      int guard;
      n_vec = 0; n_err = 0; cyc = 0;
      rst = 1'b0; d_rst = 1'b0;
      d_iv = 1'b0; d_or = 1'b1; d_a = '0; d_b = '0; d_ci = 1'b0; d_sb = 1'b0;
      #1;
      rst = 1'b1; d_rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(d_ov), 64'(0));
      chk("rst_S",         64'(d_s),  64'(0));
      chk("rst_Cout",      64'(d_co), 64'(0));
      chk("rst_ovf",       64'(d_of), 64'(0));
      chk("rst_in_ready",  64'(d_ir), 64'(1));
      repeat (3) @(negedge clk);
      rst = 1'b0; d_rst = 1'b0;

      corner("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      corner("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      corner("add_cin",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      corner("add_negov", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      corner("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      corner("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      corner("sub_bin",   16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      corner("sub_zero",  16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

      // reset with three beats in flight and the head beat stalled
      @(negedge clk);
      d_or = 1'b0; d_iv = 1'b1; d_sb = 1'b0; d_ci = 1'b0;
      d_a = 16'h1111; d_b = 16'h2222;
      @(negedge clk);
      d_a = 16'h3333; d_b = 16'h4444;
      @(negedge clk);
      d_a = 16'h5555; d_b = 16'h6666;
      @(negedge clk);
      d_iv = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_rst_valid", 64'(d_ov), 64'(1));
      chk("pre_rst_S",     64'(d_s),  64'(16'h3333));
      chk("pre_rst_rdy",   64'(d_ir), 64'(0));
      d_rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(d_ov), 64'(0));
      chk("mid_rst_S",     64'(d_s),  64'(0));
      chk("mid_rst_Cout",  64'(d_co), 64'(0));
      chk("mid_rst_ovf",   64'(d_of), 64'(0));
      chk("mid_rst_rdy",   64'(d_ir), 64'(1));
      @(negedge clk);
      @(negedge clk);
      d_rst = 1'b0; d_or = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         #1;
         if (d_ov) cnt++;
      end
      chk("rst_stale", 64'(cnt), 64'(0));
      corner("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

      guard = 0;
      while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done)
             && guard < 40000) begin
         @(negedge clk);
         guard++;
      end
      chk("sweep_done", 64'(g_sw[0].done && g_sw[1].done
                           && g_sw[2].done && g_sw[3].done), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined N-bit adder/subtractor with valid/ready handshaking. It is the sequential successor of the team's 16-bit combinational ripple adder. Carry propagation is split into SEG-bit segments, with one segment resolved per pipeline stage, so the critical path stays at one segment regardless of N. It serves as the accumulation/partial-product adder stage feeding the array multiplier datapath.

## Interface
- N, 16, operand/result width; must be a multiple of SEG
- SEG, 4, bits resolved per stage; STAGES = N/SEG (SEG = N gives one stage)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand beat offered
- in_ready  output  1  operand beat accepted this cycle when high with in_valid
- A  input  N  operand A (unsigned or two's complement)
- B  input  N  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- S  output  N  result
- Cout  output  1  carry-out (add) / not-borrow (sub)
- ovf  output  1  signed two's-complement overflow

## Operation
- Arithmetic, per accepted beat:
  - Beff = sub ? ~B : B.
  - c0 = sub ? ~cin : cin.
  - {Cout,S} = A + Beff + c0, exact to N+1 bits.
  - Add: {Cout,S} = A+B+cin.
  - Sub: S = A−B−cin mod 2^N; Cout=1 iff no borrow.
- ovf = (A[N-1] == Beff[N-1]) && (S[N-1] != A[N-1]).
- Stage k (0..STAGES-1):
  - Adds segment k of A and Beff with the carry registered from stage k−1 (stage 0 uses c0).
  - Registers that sum segment and its carry.
  - Forwards the still-unused upper operand segments and the already-resolved lower sum segments alongside (skew registers).
- Each stage holds a valid bit. The output stage register drives S, Cout, ovf and out_valid directly.
- Flow control is a single global stall:
  - stall = out_valid && !out_ready.
  - While stall is high, every stage register and valid bit holds, bubbles included.
  - in_ready = !stall. This is a combinational path from out_ready and is permitted.
- When not stalled, every stage advances one position.
  - Stage 0 loads the operands with valid = in_valid.
  - A beat with in_valid low inserts a bubble.
- Results emerge strictly in acceptance order; no beat is dropped or duplicated.

## Timing
- Reset, asynchronous and immediate:
  - All valid bits = 0, out_valid = 0.
  - S = 0, Cout = 0, ovf = 0, in_ready = 1.
  - All data registers = 0.
- Reset mid-operation discards every in-flight beat; no partial result appears after release.
- Latency:
  - A beat accepted at edge t presents out_valid=1 with its result after edge t+STAGES−1, with no stall.
  - This is STAGES cycles from the acceptance cycle to the result cycle.
  - N=16, SEG=4: accepted at edge 0, visible after edge 3.
- Throughput is one beat per cycle with out_ready held high.
- During a stall, S, Cout, ovf and out_valid remain stable until the handshake completes.
- Simultaneous events:
  - If out_valid && out_ready and in_valid in the same cycle, the output beat retires and the input beat is accepted on the same edge.
  - With out_ready low and out_valid low, the pipeline still advances, since stall requires out_valid.
- Wrap-around:
  - 0xFFFF+0x0001 gives S=0x0000, Cout=1.
  - A carry must ripple through all STAGES correctly across cycles.
- Changes on A, B, cin or sub while in_ready=0 have no effect.

## Test plan
- **Reset check:** assert rst mid-stream with 3 beats in flight, release it -> out_valid=0, S=0, Cout=0, ovf=0, in_ready=1; no stale beat ever emerges.
- **Add corners** (N=16, SEG=4, out_ready=1):
  - 0xFFFF+0x0001, cin=0 -> S=0x0000, Cout=1, ovf=0, exactly 4 cycles later.
  - 0x7FFF+0x0001 -> S=0x8000, ovf=1.
  - 0xFFFF+0xFFFF, cin=1 -> S=0xFFFF, Cout=1.
- **Subtract:**
  - 0x0005−0x0007, sub=1, cin=0 -> S=0xFFFE, Cout=0.
  - 0x8000−0x0001 -> S=0x7FFF, ovf=1, Cout=1.
  - 0x1234−0x1234, cin=1 -> S=0xFFFF, Cout=0.
- **Throughput:** 10,000 back-to-back random beats with random sub/cin and out_ready=1 -> one result per cycle, in order, each matching the N+1-bit reference model.
- **Backpressure:**
  - Random out_ready (50%) with random in_valid.
  - Required: S/Cout/ovf stay stable whenever out_valid && !out_ready; in_ready = !(out_valid && !out_ready).
  - Every accepted beat appears exactly once, in order.
- **Parameter sweep:** rerun the random test for (N,SEG) = (16,16), (16,1), (32,8) -> latency equals N/SEG and all results are exact.
